// File: rtl/shift_ex_stage_pkg.sv
// Shared definitions for the execute-stage shift unit: op encodings and datapath widths.
package shift_ex_stage_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_ROTR = 2'b11;

endpackage

// File: rtl/shift_ex_stage_core.sv
// Combinational 32-bit shifter: SLL, SRL, SRA, ROTR by b[4:0].
module shift32_core
  import shift_ex_stage_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [1:0]      op,
  output logic [XLEN-1:0] res
);

  logic [SHAMT_W-1:0] sh;
  logic [SHAMT_W:0]   rot_left;
  logic               unused_b_hi;

  assign sh          = b[SHAMT_W-1:0];
  assign unused_b_hi = ^b[XLEN-1:SHAMT_W];
  // A left shift by the full width yields zero, so sh=0 rotates back to a.
  assign rot_left    = (SHAMT_W+1)'(XLEN) - {1'b0, sh};

  always_comb begin
    res = a;
    case (op)
      OP_SLL:  res = a << sh;
      OP_SRL:  res = a >> sh;
      OP_SRA:  res = $unsigned($signed(a) >>> sh);
      OP_ROTR: res = (a >> sh) | (a << rot_left);
      default: res = a;
    endcase
  end

endmodule

// File: rtl/shift_ex_stage.sv
// Execute-stage shift unit: computes on accept and buffers results in a DEPTH-entry FIFO for writeback.
module shift_ex_stage
  import shift_ex_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_op,
  input  logic [XLEN-1:0]          in_A,
  input  logic [XLEN-1:0]          in_B,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_res,
  output logic                     out_zero,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   busy_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Handshakes: a transfer happens on the rising edge where valid && ready.
  // in_ready and out_valid depend only on registered occupancy, never on the
  // opposite side's ready, so a full queue does not accept even while popping.
  logic [XLEN-1:0]  res_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  core_res;
  logic             push, pop;

  shift32_core u_core (
    .a   (in_A),
    .b   (in_B),
    .op  (in_op),
    .res (core_res)
  );

  assign in_ready  = (count < DEPTH_C);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign busy_cnt  = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      res_mem[wr_ptr] <= core_res;
      tag_mem[wr_ptr] <= in_tag;
    end
  end

  assign out_res  = out_valid ? res_mem[rd_ptr] : '0;
  assign out_tag  = out_valid ? tag_mem[rd_ptr] : '0;
  assign out_zero = out_valid && (res_mem[rd_ptr] == '0);

endmodule

// File: tb/tb_shift_ex_stage.sv
// Directed bench for shift_ex_stage: op vectors, back-pressure, streaming, zero flag, async reset.
module tb_shift_ex_stage;

  localparam logic [1:0] SLL  = 2'b00;
  localparam logic [1:0] SRL  = 2'b01;
  localparam logic [1:0] SRA  = 2'b10;
  localparam logic [1:0] ROTR = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_A = '0;
  logic [31:0] in_B = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_res;
  logic        out_zero;
  logic [4:0]  out_tag;
  logic [1:0]  busy_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  shift_ex_stage #(.DEPTH(2), .TAG_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_A      (in_A),
    .in_B      (in_B),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_zero  (out_zero),
    .out_tag   (out_tag),
    .busy_cnt  (busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with out_ready=1: pushes one op, then checks it at the next negedge.
  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag,
                       input logic [31:0] exp_res);
    in_valid = 1'b1;
    in_op    = op;
    in_A     = a;
    in_B     = b;
    in_tag   = tag;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({name, "_res"}, out_res, exp_res);
    check({name, "_tag"}, {27'd0, out_tag}, {27'd0, tag});
    check({name, "_zero"}, {31'd0, out_zero}, {31'd0, exp_res == 32'd0});
  endtask

  task automatic push_only(input logic [4:0] tag);
    in_valid = 1'b1;
    in_op    = SRL;
    in_A     = {27'd0, tag} << 4;
    in_B     = 32'd4;
    in_tag   = tag;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain_one;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // reset
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {30'd0, busy_cnt}, 32'd0);
    check("rst_out_res", out_res, 32'd0);
    check("rst_out_zero", {31'd0, out_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;

    // SRL basics, op coverage and B masking
    do_op("srl_a5_2", SRL, 32'hA5, 32'd2, 5'd3, 32'h29);
    do_op("srl_a5_1", SRL, 32'hA5, 32'd1, 5'd4, 32'h52);
    do_op("sra_neg", SRA, 32'h8000_0000, 32'd4, 5'd5, 32'hF800_0000);
    do_op("sra_pos", SRA, 32'h7000_0000, 32'd4, 5'd6, 32'h0700_0000);
    do_op("sll_31", SLL, 32'd1, 32'd31, 5'd7, 32'h8000_0000);
    do_op("rotr_1", ROTR, 32'd1, 32'd1, 5'd8, 32'h8000_0000);
    do_op("rotr_8", ROTR, 32'h1234_5678, 32'd8, 5'd9, 32'h7812_3456);
    do_op("rotr_0", ROTR, 32'h1234_5678, 32'd0, 5'd10, 32'h1234_5678);
    do_op("srl_mask", SRL, 32'hA5, 32'h21, 5'd11, 32'h52);
    do_op("sll_0", SLL, 32'hFFFF_FFFF, 32'd0, 5'd12, 32'hFFFF_FFFF);
    do_op("sra_mask0", SRA, 32'h8000_0001, 32'hFFFF_FFE0, 5'd13, 32'h8000_0001);
    do_op("zero_flag", SRL, 32'h0000_00FF, 32'd8, 5'd14, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("drain_empty", {31'd0, out_valid}, 32'd0);

    // back-pressure
    out_ready = 1'b0;
    push_only(5'd1);
    push_only(5'd2);
    check("bp_busy2", {30'd0, busy_cnt}, 32'd2);
    check("bp_in_ready0", {31'd0, in_ready}, 32'd0);
    push_only(5'd3);
    check("bp_no_accept", {30'd0, busy_cnt}, 32'd2);
    check("bp_head1", {27'd0, out_tag}, 32'd1);
    out_ready = 1'b1;
    #1;
    check("bp_ready_state_only", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("bp_head2", {27'd0, out_tag}, 32'd2);
    check("bp_res2", out_res, 32'd2);
    check("bp_in_ready1", {31'd0, in_ready}, 32'd1);
    check("bp_busy1", {30'd0, busy_cnt}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("bp_empty", {31'd0, out_valid}, 32'd0);
    check("bp_busy0", {30'd0, busy_cnt}, 32'd0);

    // streaming with scoreboard
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = SRL;
    in_B      = 32'd4;
    for (int i = 0; i < 16; i++) begin
      in_tag = 5'(i);
      in_A   = 32'(i) << 4;
      @(posedge clk);
      if (in_ready) exp_q.push_back(32'(i));
      @(negedge clk);
      check("stream_busy", {30'd0, busy_cnt}, 32'd1);
      if (exp_q.size() != 0) begin
        check("stream_tag", {27'd0, out_tag}, exp_q[0]);
        check("stream_res", out_res, exp_q.pop_front());
      end else begin
        check("stream_q_nonempty", 32'd0, 32'd1);
      end
    end
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("stream_end_empty", {31'd0, out_valid}, 32'd0);

    // async reset mid-operation
    out_ready = 1'b0;
    push_only(5'd5);
    push_only(5'd6);
    check("rr_busy2", {30'd0, busy_cnt}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("rr_out_valid", {31'd0, out_valid}, 32'd0);
    check("rr_busy0", {30'd0, busy_cnt}, 32'd0);
    check("rr_in_ready", {31'd0, in_ready}, 32'd1);
    check("rr_out_res", out_res, 32'd0);
    check("rr_out_tag", {27'd0, out_tag}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    do_op("rr_new", SLL, 32'd3, 32'd2, 5'd9, 32'd12);
    check("rr_busy1", {30'd0, busy_cnt}, 32'd1);
    drain_one();
    check("rr_no_stale", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
